udp_tx_sched: RTL and testbench

//  Transmit-side scheduler for the HDMI-over-UDP link. Shares one GMII TX

---
 rtl/udp_tx_sched.sv | 148 ++++++++++++++
 tb/tb_udp_tx_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_sched.sv
// Transmit scheduler sharing one GMII packet builder between video and AUX/audio packetisers.
// Whole-packet grants with urgent-audio override, round-robin, inter-frame gap and watchdog abort.
module udp_tx_sched #(
  parameter logic [7:0]  IFG_CYCLES     = 8'd12,
  parameter logic [11:0] AUX_URGENT_LVL = 12'd48,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2048
) (
  input  logic        clk125,
  input  logic        sys_rst_n,
  input  logic        vid_req,
  input  logic        aux_req,
  input  logic [11:0] aux_level,
  input  logic        tx_done,
  output logic        grant_vid,
  output logic        grant_aux,
  output logic        tx_start,
  output logic [7:0]  pkt_type,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_IFG    = 2'd2;

  localparam logic GNT_VID = 1'b0;
  localparam logic GNT_AUX = 1'b1;

  localparam logic [7:0] TYPE_VID = 8'h00;
  localparam logic [7:0] TYPE_AUX = 8'h01;

  logic [1:0]  state_q, state_d;
  logic [15:0] wdog_q, wdog_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic        last_gnt_q, last_gnt_d;
  logic        grant_vid_q, grant_vid_d;
  logic        grant_aux_q, grant_aux_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  pkt_type_q, pkt_type_d;
  logic        busy_q, busy_d;
  logic        timeout_err_q, timeout_err_d;

  logic        win;
  logic        win_aux;

  // Urgent audio beats round-robin; with both pending, the side not served last wins.
  always_comb begin
    win     = 1'b0;
    win_aux = 1'b0;
    if (aux_req && (aux_level >= AUX_URGENT_LVL)) begin
      win     = 1'b1;
      win_aux = 1'b1;
    end else if (vid_req && aux_req) begin
      win     = 1'b1;
      win_aux = (last_gnt_q == GNT_VID);
    end else if (vid_req) begin
      win     = 1'b1;
      win_aux = 1'b0;
    end else if (aux_req) begin
      win     = 1'b1;
      win_aux = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wdog_d        = wdog_q;
    ifg_cnt_d     = ifg_cnt_q;
    last_gnt_d    = last_gnt_q;
    grant_vid_d   = grant_vid_q;
    grant_aux_d   = grant_aux_q;
    pkt_type_d    = pkt_type_q;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win) begin
          grant_vid_d = ~win_aux;
          grant_aux_d = win_aux;
          tx_start_d  = 1'b1;
          pkt_type_d  = win_aux ? TYPE_AUX : TYPE_VID;
          last_gnt_d  = win_aux ? GNT_AUX : GNT_VID;
          wdog_d      = 16'd0;
          state_d     = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        wdog_d = wdog_q + 16'd1;
        // A tx_done on the watchdog's last cycle is a normal completion.
        if (tx_done || (wdog_q == TIMEOUT_CYCLES - 16'd1)) begin
          grant_vid_d   = 1'b0;
          grant_aux_d   = 1'b0;
          ifg_cnt_d     = 8'd0;
          state_d       = S_IFG;
          timeout_err_d = ~tx_done;
        end
      end
      S_IFG: begin
        ifg_cnt_d = ifg_cnt_q + 8'd1;
        if (ifg_cnt_q == IFG_CYCLES - 8'd1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        grant_vid_d = 1'b0;
        grant_aux_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      wdog_q        <= 16'd0;
      ifg_cnt_q     <= 8'd0;
      last_gnt_q    <= GNT_AUX;
      grant_vid_q   <= 1'b0;
      grant_aux_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      pkt_type_q    <= 8'h00;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wdog_q        <= wdog_d;
      ifg_cnt_q     <= ifg_cnt_d;
      last_gnt_q    <= last_gnt_d;
      grant_vid_q   <= grant_vid_d;
      grant_aux_q   <= grant_aux_d;
      tx_start_q    <= tx_start_d;
      pkt_type_q    <= pkt_type_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant_vid   = grant_vid_q;
  assign grant_aux   = grant_aux_q;
  assign tx_start    = tx_start_q;
  assign pkt_type    = pkt_type_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched: arbitration vector table plus multi-cycle sequences.
module tb_udp_tx_sched;

  logic        clk125;
  logic        sys_rst_n;
  logic        vid_req;
  logic        aux_req;
  logic [11:0] aux_level;
  logic        tx_done;
  logic        grant_vid;
  logic        grant_aux;
  logic        tx_start;
  logic [7:0]  pkt_type;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  udp_tx_sched dut (
    .clk125      (clk125),
    .sys_rst_n   (sys_rst_n),
    .vid_req     (vid_req),
    .aux_req     (aux_req),
    .aux_level   (aux_level),
    .tx_done     (tx_done),
    .grant_vid   (grant_vid),
    .grant_aux   (grant_aux),
    .tx_start    (tx_start),
    .pkt_type    (pkt_type),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk125 = 1'b0;
  always #4 clk125 = ~clk125;

  typedef struct {
    logic        v;
    logic        a;
    logic [11:0] lvl;
    logic        exp_gv;
    logic        exp_ga;
    logic [7:0]  exp_pt;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".grant_vid"},   {31'd0, grant_vid},   32'd0);
    chk({name, ".grant_aux"},   {31'd0, grant_aux},   32'd0);
    chk({name, ".tx_start"},    {31'd0, tx_start},    32'd0);
    chk({name, ".pkt_type"},    {24'd0, pkt_type},    32'd0);
    chk({name, ".busy"},        {31'd0, busy},        32'd0);
    chk({name, ".timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk({name, ".idle_reached"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    vid_req   = 1'b0;
    aux_req   = 1'b0;
    aux_level = 12'd0;
    tx_done   = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int gap;
    logic exp_aux;
    logic [11:0] lvl_next;

    vecs[0] = '{1'b1, 1'b0, 12'd0,    1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 12'd0,    1'b0, 1'b1, 8'h01};
    vecs[2] = '{1'b1, 1'b1, 12'd0,    1'b1, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 12'd0,    1'b0, 1'b1, 8'h01};
    vecs[4] = '{1'b1, 1'b1, 12'd48,   1'b0, 1'b1, 8'h01};
    vecs[5] = '{1'b1, 1'b1, 12'd47,   1'b1, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 1'b1, 12'd4095, 1'b0, 1'b1, 8'h01};
    vecs[7] = '{1'b1, 1'b0, 12'd100,  1'b1, 1'b0, 8'h00};
    vecs[8] = '{1'b0, 1'b1, 12'd48,   1'b0, 1'b1, 8'h01};
    vecs[9] = '{1'b0, 1'b0, 12'd0,    1'b0, 1'b0, 8'h01};

    // Reset held with random inputs
    sys_rst_n = 1'b0;
    tx_done   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vid_req   = 1'($urandom);
      aux_req   = 1'($urandom);
      aux_level = 12'($urandom);
      tx_done   = 1'($urandom);
      tick();
    end
    chk_all_zero("reset_hold");
    vid_req = 1'b0; aux_req = 1'b0; aux_level = 12'd0; tx_done = 1'b0;
    sys_rst_n = 1'b1;
    tick();
    chk_all_zero("reset_release");

    // Arbitration table: last_gnt carries over from one vector to the next
    for (int i = 0; i < 10; i++) begin
      vid_req   = vecs[i].v;
      aux_req   = vecs[i].a;
      aux_level = vecs[i].lvl;
      tick();
      chk($sformatf("vec%0d.grant_vid", i), {31'd0, grant_vid}, {31'd0, vecs[i].exp_gv});
      chk($sformatf("vec%0d.grant_aux", i), {31'd0, grant_aux}, {31'd0, vecs[i].exp_ga});
      chk($sformatf("vec%0d.pkt_type", i),  {24'd0, pkt_type},  {24'd0, vecs[i].exp_pt});
      chk($sformatf("vec%0d.tx_start", i),  {31'd0, tx_start},
          {31'd0, vecs[i].exp_gv | vecs[i].exp_ga});
      chk($sformatf("vec%0d.busy", i),      {31'd0, busy},
          {31'd0, vecs[i].exp_gv | vecs[i].exp_ga});
      vid_req = 1'b0;
      aux_req = 1'b0;
      tick();
      chk($sformatf("vec%0d.start_pulse", i), {31'd0, tx_start}, 32'd0);
      chk($sformatf("vec%0d.grant_hold", i),  {31'd0, grant_vid | grant_aux},
          {31'd0, vecs[i].exp_gv | vecs[i].exp_ga});
      if (vecs[i].exp_gv | vecs[i].exp_ga) begin
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk($sformatf("vec%0d.grant_drop", i), {30'd0, grant_vid, grant_aux}, 32'd0);
        wait_idle($sformatf("vec%0d", i));
      end
    end

    // Single video packet, tx_done in ACTIVE cycle 100
    do_reset();
    vid_req = 1'b1;
    tick();
    chk("single.tx_start", {31'd0, tx_start}, 32'd1);
    chk("single.grant_vid", {31'd0, grant_vid}, 32'd1);
    chk("single.pkt_type", {24'd0, pkt_type}, 32'h00);
    vid_req = 1'b0;
    tick();
    chk("single.tx_start_pulse", {31'd0, tx_start}, 32'd0);
    repeat (98) tick();
    chk("single.grant_c100", {31'd0, grant_vid}, 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("single.grant_drop", {31'd0, grant_vid}, 32'd0);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("single.ifg_busy_cycles", n, 32'd12);
    // tx_done outside ACTIVE is ignored
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("single.idle_tx_done", {30'd0, busy, grant_vid}, 32'd0);

    // Round-robin, then urgent override, with 13-cycle grant gaps
    do_reset();
    vid_req = 1'b1;
    aux_req = 1'b1;
    aux_level = 12'd0;
    tick();
    for (int k = 0; k < 6; k++) begin
      exp_aux = (k == 1) || (k == 3) || (k == 4);
      chk($sformatf("rr%0d.grant_vid", k), {31'd0, grant_vid}, {31'd0, ~exp_aux});
      chk($sformatf("rr%0d.grant_aux", k), {31'd0, grant_aux}, {31'd0, exp_aux});
      lvl_next = (k == 3) ? 12'd48 : ((k == 4) ? 12'd47 : 12'd0);
      aux_level = lvl_next;
      repeat (49) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (k < 5) begin
        gap = 0;
        while (!(grant_vid || grant_aux) && gap < 40) begin
          tick();
          gap++;
        end
        chk($sformatf("rr%0d.gap", k), gap, 32'd13);
      end
    end
    vid_req = 1'b0;
    aux_req = 1'b0;
    aux_level = 12'd0;
    wait_idle("rr_end");

    // Watchdog abort after 2048 ACTIVE cycles, then re-arbitration
    vid_req = 1'b1;
    tick();
    chk("wd.grant", {31'd0, grant_vid}, 32'd1);
    n = 0;
    while (!timeout_err && n < 3000) begin
      tick();
      n++;
    end
    chk("wd.timeout_cycle", n, 32'd2048);
    chk("wd.grant_drop", {30'd0, grant_vid, grant_aux}, 32'd0);
    chk("wd.busy", {31'd0, busy}, 32'd1);
    gap = 0;
    tick();
    gap++;
    chk("wd.err_pulse", {31'd0, timeout_err}, 32'd0);
    while (!grant_vid && gap < 40) begin
      tick();
      gap++;
    end
    chk("wd.regrant_gap", gap, 32'd13);
    vid_req = 1'b0;
    // This packet ends with tx_done exactly on ACTIVE cycle 2048
    repeat (2047) tick();
    chk("wd2.grant_c2048", {31'd0, grant_vid}, 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("wd2.no_err", {31'd0, timeout_err}, 32'd0);
    chk("wd2.grant_drop", {31'd0, grant_vid}, 32'd0);
    tick();
    chk("wd2.no_err_late", {31'd0, timeout_err}, 32'd0);
    wait_idle("wd2");

    // Reset mid-ACTIVE clears outputs without a clock edge
    aux_req = 1'b1;
    tick();
    chk("mid.grant_aux", {31'd0, grant_aux}, 32'd1);
    chk("mid.pkt_type", {24'd0, pkt_type}, 32'h01);
    repeat (5) tick();
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    vid_req = 1'b1;
    aux_req = 1'b1;
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("post_reset.grant_vid", {31'd0, grant_vid}, 32'd1);
    chk("post_reset.grant_aux", {31'd0, grant_aux}, 32'd0);
    chk("post_reset.pkt_type", {24'd0, pkt_type}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
